// File: rtl/axis_packet_fifo.sv
// AXI-Stream packet FIFO: first-word fall-through, per-packet accounting.
// Define AXIS_PKT_FIFO_STORE_FWD_EN to hold output until a whole packet is stored.
module axis_packet_fifo #(
  parameter int TDATA_WIDTH = 32,
  parameter int DEPTH       = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = TDATA_WIDTH / 8;
  localparam int EW = TDATA_WIDTH + KW + 1;
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic                   last;
    logic [KW-1:0]          keep;
    logic [TDATA_WIDTH-1:0] data;
  } entry_t;

  entry_t      mem_q [DEPTH];
  entry_t      head;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;
  logic        live_q;
  logic        push, pop;
  logic        release_ok;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // live_q keeps the slave side closed until the first edge out of reset
  assign s_axis_tready = live_q & ~full;

  assign push = s_axis_tvalid & s_axis_tready;
  assign pop  = m_axis_tvalid & m_axis_tready;

  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis_tdata = head.data;
  assign m_axis_tkeep = head.keep;
  assign m_axis_tlast = head.last;

  assign m_axis_tvalid = ~empty & release_ok;

  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign pkt_count = pkt_cnt_q;

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
  logic in_pkt_q, in_pkt_d;

  // A full FIFO releases anyway so an oversized packet cannot stall;
  // once a packet starts leaving it drains through to its tlast.
  assign release_ok = (pkt_cnt_q != '0) | full | in_pkt_q;

  // Track whether the head packet has already begun output
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (pop) in_pkt_d = ~m_axis_tlast;
  end

  // Head-packet release state
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) in_pkt_q <= 1'b0;
    else        in_pkt_q <= in_pkt_d;
  end
`else
  assign release_ok = 1'b1;
`endif

  // Pointer and packet-count next state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE;
    unique case ({push & s_axis_tlast, pop & m_axis_tlast})
      2'b10:   pkt_cnt_d = pkt_cnt_q + ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      live_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      live_q    <= 1'b1;
    end
  end

  // Storage write; contents are left as-is across reset
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Randomized and directed bench for axis_packet_fifo against a queue model.
// Store-and-forward checks run when AXIS_PKT_FIFO_STORE_FWD_EN is defined.
module tb_axis_packet_fifo;

  localparam int W  = 32;
  localparam int K  = W / 8;
  localparam int D  = 16;
  localparam int PW = $clog2(D) + 1;
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
  localparam bit SF = 1'b1;
`else
  localparam bit SF = 1'b0;
`endif

  typedef struct packed {
    logic         last;
    logic [K-1:0] keep;
    logic [W-1:0] data;
  } ent_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [W-1:0]  s_tdata;
  logic [K-1:0]  s_tkeep;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic [K-1:0]  m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] pkt_count;
  logic          full;
  logic          empty;

  axis_packet_fifo #(.TDATA_WIDTH(W), .DEPTH(D)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .occupancy     (occupancy),
    .pkt_count     (pkt_count),
    .full          (full),
    .empty         (empty)
  );

  always #5 aclk = ~aclk;

  int   n_chk  = 0;
  int   n_fail = 0;
  ent_t q[$];
  bit   armed;
  bit   started;
  int   pops_seen;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mdl_pkts();
    int n = 0;
    foreach (q[i]) if (q[i].last) n++;
    return n;
  endfunction

  function automatic bit mdl_valid();
    if (q.size() == 0) return 1'b0;
    if (!SF) return 1'b1;
    return (mdl_pkts() > 0) || (q.size() == D) || started;
  endfunction

  function automatic bit mdl_ready();
    return armed && (q.size() < D);
  endfunction

  task automatic verify(input string tag);
    check({tag, ".occ"},   occupancy, q.size());
    check({tag, ".pkt"},   pkt_count, mdl_pkts());
    check({tag, ".empty"}, empty,     q.size() == 0);
    check({tag, ".full"},  full,      q.size() == D);
    check({tag, ".srdy"},  s_tready,  mdl_ready());
    check({tag, ".mvld"},  m_tvalid,  mdl_valid());
    if (mdl_valid()) begin
      check({tag, ".data"}, m_tdata, q[0].data);
      check({tag, ".keep"}, m_tkeep, q[0].keep);
      check({tag, ".last"}, m_tlast, q[0].last);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, verify at negedge
  task automatic cyc(input string tag, input logic sv, input logic [W-1:0] d,
                     input logic [K-1:0] k, input logic l, input logic mr);
    bit   do_push, do_pop;
    ent_t e;
    s_tvalid = sv;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    m_tready = mr;
    do_push  = sv && mdl_ready();
    do_pop   = mdl_valid() && mr;
    e.last = l;
    e.keep = k;
    e.data = d;
    @(posedge aclk);
    if (do_pop) begin
      started = !q[0].last;
      void'(q.pop_front());
      pops_seen++;
    end
    if (do_push) q.push_back(e);
    armed = 1'b1;
    @(negedge aclk);
    verify(tag);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #1;
    q.delete();
    armed   = 1'b0;
    started = 1'b0;
    repeat (2) begin
      check("rst.occ",  occupancy, 0);
      check("rst.pkt",  pkt_count, 0);
      check("rst.empty", empty, 1);
      check("rst.full", full, 0);
      check("rst.mvld", m_tvalid, 0);
      check("rst.srdy", s_tready, 0);
      @(negedge aclk);
    end
    areset = 1'b0;
    #1;
    check("rel.srdy", s_tready, 0);
  endtask

  task automatic idle(input string tag, input int n, input logic mr);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, '0, '0, 1'b0, mr);
  endtask

  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    armed    = 1'b0;
    started  = 1'b0;
    pops_seen = 0;
    @(negedge aclk);
    do_reset();

    // Single word, cut-through latency of one cycle
    cyc("one.arm", 1'b0, '0, '0, 1'b0, 1'b1);
    check("one.srdy_up", s_tready, 1);
    cyc("one.push", 1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    if (!SF) check("one.vld_next", m_tvalid, 1);
    check("one.dout", m_tdata, 32'hDEADBEEF);
    idle("one.drain", 2, 1'b1);
    check("one.occ0", occupancy, 0);
    check("one.pkt0", pkt_count, 0);

    // Fill to full, overflow attempt, then drain in order
    for (int i = 0; i < D; i++)
      cyc("fill", 1'b1, W'(i), 4'hF, 1'b0, 1'b0);
    check("fill.full", full, 1);
    check("fill.occ",  occupancy, D);
    cyc("fill.ovf", 1'b1, 32'h0BAD, 4'h1, 1'b1, 1'b0);
    check("fill.occ_hold", occupancy, D);
    for (int i = 0; i < D; i++) begin
      check("drain.order", m_tdata, W'(i));
      cyc("drain", 1'b0, '0, '0, 1'b0, 1'b1);
    end
    idle("drain.tail", 2, 1'b1);
    check("drain.empty", empty, 1);

    // Continuous streaming across pointer wrap
    pops_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cyc("stream", 1'b1, W'(32'h1000 + i), K'($urandom), (i % 10) == 9, 1'b1);
      if (!SF && i > 0) check("stream.occ1", occupancy, 1);
    end
    idle("stream.tail", 20, 1'b1);
    check("stream.count", pops_seen, 100);

    if (SF) begin
      // 4-word packet with a gap before tlast
      cyc("sf4.w0", 1'b1, 32'hA0, 4'hF, 1'b0, 1'b1);
      cyc("sf4.w1", 1'b1, 32'hA1, 4'hF, 1'b0, 1'b1);
      cyc("sf4.w2", 1'b1, 32'hA2, 4'hF, 1'b0, 1'b1);
      check("sf4.hold", m_tvalid, 0);
      idle("sf4.gap", 2, 1'b1);
      check("sf4.hold2", m_tvalid, 0);
      cyc("sf4.w3", 1'b1, 32'hA3, 4'h3, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
        check("sf4.beat_vld", m_tvalid, 1);
        check("sf4.beat_dat", m_tdata, W'(32'hA0 + i));
        check("sf4.beat_lst", m_tlast, i == 3);
        cyc("sf4.out", 1'b0, '0, '0, 1'b0, 1'b1);
      end
      // Oversized packet released once full
      pops_seen = 0;
      for (int i = 0; i < 20; i++)
        cyc("sf20", 1'b1, W'(32'hB00 + i), 4'hF, 1'b0, 1'b1);
      idle("sf20.tail", 25, 1'b1);
      check("sf20.count", pops_seen, 20);
    end

    // Reset mid-packet discards everything
    cyc("mid.w0", 1'b1, 32'hC0, 4'hF, 1'b0, 1'b0);
    cyc("mid.w1", 1'b1, 32'hC1, 4'hF, 1'b0, 1'b0);
    cyc("mid.w2", 1'b1, 32'hC2, 4'hF, 1'b0, 1'b0);
    check("mid.occ3", occupancy, 3);
    do_reset();
    cyc("post.arm", 1'b0, '0, '0, 1'b0, 1'b0);
    cyc("post.w0", 1'b1, 32'hE0, 4'hF, 1'b0, 1'b0);
    cyc("post.w1", 1'b1, 32'hE1, 4'hC, 1'b1, 1'b0);
    check("post.occ", occupancy, 2);
    check("post.head", m_tdata, 32'hE0);
    idle("post.drain", 3, 1'b1);
    check("post.empty", empty, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc("rand", ($urandom % 4) != 0, W'($urandom), K'($urandom),
          ($urandom % 5) == 0, ($urandom % 3) != 0);
      if (i == 700) begin
        do_reset();
        cyc("rand.arm", 1'b0, '0, '0, 1'b0, 1'b0);
      end
    end
    for (int i = 0; i < 5; i++)
      cyc("rand.flush", 1'b1, W'(32'hF0 + i), 4'hF, 1'b1, 1'b1);
    idle("rand.end", 30, 1'b1);
    check("rand.empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
